// File: rtl/avg_row_interp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : avg_pkg
// Brief   : Shared types, rounding constants and the two-sample averaging helper.
// Revision: 1.0
// ============================================================================
package avg_pkg;

   typedef enum logic [0:0] {
      FILL   = 1'b0,
      STREAM = 1'b1
   } state_t;

   localparam logic RND_TRUNC   = 1'b0;
   localparam logic RND_HALF_UP = 1'b1;

   // Widest sample the helper supports; callers size-cast in and out.
   localparam int AVG_MAX_W = 32;

   function automatic logic [AVG_MAX_W-1:0] avg2(input logic [AVG_MAX_W-1:0] a,
                                                 input logic [AVG_MAX_W-1:0] b,
                                                 input logic                 rnd);
      logic [AVG_MAX_W:0] sum;
      sum = {1'b0, a} + {1'b0, b} + {{AVG_MAX_W{1'b0}}, rnd};
      return AVG_MAX_W'(sum >> 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/avg_row_interp_if.sv
`default_nettype none
// ============================================================================
// Module  : avg_row_interp_if
// Brief   : Pixel-in / averaged-pixel-out bundle for the row averager.
// Revision: 1.0
// ============================================================================
interface avg_row_interp_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] data;
   logic              in_valid;
   logic              round_mode;
   logic              valid;
   logic [DATA_W-1:0] out;
   logic              done;

   modport master (
      output data, in_valid, round_mode,
      input  valid, out, done
   );

   modport slave (
      input  data, in_valid, round_mode,
      output valid, out, done
   );
endinterface
`default_nettype wire

// File: rtl/avg_row_interp_line_buffer.sv
`default_nettype none
// ============================================================================
// Module  : line_buffer
// Brief   : One-row sample store, combinational read, synchronous write.
// Revision: 1.0
// ============================================================================
module line_buffer #(
   parameter int DATA_W = 8,
   parameter int COLS   = 8,
   parameter int AW     = 3
) (
   input  wire logic              clk,
   input  wire logic              wr_en,
   input  wire logic [AW-1:0]     wr_addr,
   input  wire logic [DATA_W-1:0] wr_data,
   input  wire logic [AW-1:0]     rd_addr,
   output      logic [DATA_W-1:0] rd_data
);
   logic [DATA_W-1:0] r_mem   [COLS];
   logic [DATA_W-1:0] w_words [2**AW];

   // Address space is padded to a power of two so the read index needs no guard.
   for (genvar i = 0; i < 2**AW; i++) begin : g_word
      if (i < COLS) begin : g_live
         always_ff @(posedge clk) begin
            if (wr_en && (wr_addr == AW'(i)))
               r_mem[i] <= wr_data;
         end
         assign w_words[i] = r_mem[i];
      end else begin : g_pad
         assign w_words[i] = '0;
      end
   end

   // Read returns the pre-edge contents, so a same-address write is seen next cycle.
   assign rd_data = w_words[rd_addr];

endmodule
`default_nettype wire

// File: rtl/avg_row_interp.sv
`default_nettype none
// ============================================================================
// Module  : avg_row_interp
// Brief   : Streaming vertical averager of each sample with the one above it.
// Revision: 1.0
// ============================================================================
module avg_row_interp
   import avg_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int COLS   = 8,
   parameter int ROWS   = 16
) (
   input wire logic         clk,
   input wire logic         reset,
   avg_row_interp_if.slave  bus
);
   localparam int c_CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int c_RW = $clog2(ROWS);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [c_CW-1:0]   r_col;
   logic [c_RW-1:0]   r_row;
   logic              w_last_col;
   logic              w_last_row;
   logic              w_stream_acc;
   logic              w_done_nxt;
   logic              w_wr_en;
   logic [DATA_W-1:0] w_above;
   logic [DATA_W-1:0] w_avg;
   logic              r_valid;
   logic              r_done;
   logic [DATA_W-1:0] r_out;

   assign w_last_col = (r_col == c_CW'(COLS - 1));
   assign w_last_row = (r_row == c_RW'(ROWS - 1));
   assign w_wr_en    = bus.in_valid & ~reset;

   line_buffer #(
      .DATA_W (DATA_W),
      .COLS   (COLS),
      .AW     (c_CW)
   ) u_line_buffer (
      .clk     (clk),
      .wr_en   (w_wr_en),
      .wr_addr (r_col),
      .wr_data (bus.data),
      .rd_addr (r_col),
      .rd_data (w_above)
   );

   assign w_avg = DATA_W'(avg2(AVG_MAX_W'(w_above), AVG_MAX_W'(bus.data), bus.round_mode));

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= FILL;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_stream_acc = 1'b0;
      w_done_nxt   = 1'b0;
      case (r_state)
         FILL: begin
            if (bus.in_valid && w_last_col)
               w_state_nxt = STREAM;
         end
         STREAM: begin
            w_stream_acc = bus.in_valid;
            w_done_nxt   = bus.in_valid & w_last_col & w_last_row;
            if (w_done_nxt)
               w_state_nxt = FILL;
         end
         default: w_state_nxt = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_col <= '0;
         r_row <= '0;
      end else if (bus.in_valid) begin
         if (w_last_col) begin
            r_col <= '0;
            r_row <= w_last_row ? '0 : r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   // out holds between STREAM samples; only valid/done are pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_done  <= 1'b0;
         r_out   <= '0;
      end else begin
         r_valid <= w_stream_acc;
         r_done  <= w_done_nxt;
         if (w_stream_acc)
            r_out <= w_avg;
      end
   end

   assign bus.valid = r_valid;
   assign bus.done  = r_done;
   assign bus.out   = r_out;

endmodule
`default_nettype wire

// File: tb/tb_avg_row_interp.sv
`default_nettype none
// ============================================================================
// Module  : tb_avg_row_interp
// Brief   : Scoreboarded bench for the row averager, default and tiny geometry.
// Revision: 1.0
// ============================================================================
module tb_avg_row_interp;
   import avg_pkg::*;

   localparam int DW = 8;
   localparam int NC = 8;
   localparam int NR = 16;

   logic clk = 1'b0;
   logic reset;
   logic sreset;
   always #5 clk = ~clk;

   avg_row_interp_if #(.DATA_W(DW)) bus ();
   avg_row_interp_if #(.DATA_W(4))  sbus ();

   avg_row_interp #(.DATA_W(DW), .COLS(NC), .ROWS(NR)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   avg_row_interp #(.DATA_W(4), .COLS(3), .ROWS(2)) sdut (
      .clk   (clk),
      .reset (sreset),
      .bus   (sbus)
   );

   typedef struct { int val; bit done; int cyc; } exp_t;
   typedef struct { int val; bit done; } cap_t;

   exp_t sb[$];
   cap_t cap[$];
   int   ref_q[$];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int m_buf[NC];
   int m_col  = 0;
   int m_row  = 0;
   bit mon_en = 1'b0;
   int last_out = 0;
   logic rst_prev = 1'b1;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_prev <= reset;
   end

   // Output monitor: pops the scoreboard on each valid, checks hold on idle cycles.
   always @(negedge clk) begin : mon
      exp_t e;
      if (mon_en) begin
         if (rst_prev) begin
            last_out = int'(bus.out);
         end else if (bus.valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_valid: out=%0d done=%0b, no output expected", bus.out, bus.done);
            end else begin
               e = sb.pop_front();
               if (bus.out !== DW'(e.val) || bus.done !== e.done || cyc != e.cyc) begin
                  errors++;
                  $display("FAIL scoreboard: out=%0d done=%0b cyc=%0d, expected out=%0d done=%0b cyc=%0d",
                           bus.out, bus.done, cyc, e.val, e.done, e.cyc);
               end
            end
            cap.push_back('{int'(bus.out), bus.done});
            last_out = int'(bus.out);
         end else begin
            checks++;
            if (bus.done !== 1'b0 || bus.out !== DW'(last_out)) begin
               errors++;
               $display("FAIL idle_hold: out=%0d done=%0b, expected out=%0d done=0", bus.out, bus.done, last_out);
            end
         end
      end
   end

   task automatic send(input int d, input bit rm);
      @(negedge clk);
      bus.data       = DW'(d);
      bus.in_valid   = 1'b1;
      bus.round_mode = rm;
      if (m_row > 0)
         sb.push_back('{(m_buf[m_col] + d + int'(rm)) / 2, (m_row == NR-1) && (m_col == NC-1), cyc + 1});
      m_buf[m_col] = d;
      if (m_col == NC-1) begin
         m_col = 0;
         m_row = (m_row == NR-1) ? 0 : m_row + 1;
      end else begin
         m_col++;
      end
   endtask

   task automatic idle();
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      idle();
      repeat (3) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d outputs missing, expected 0", name, sb.size());
      end
   endtask

   task automatic count_done(output int n, output int last_idx);
      n = 0; last_idx = -1;
      foreach (cap[i]) if (cap[i].done) begin n++; last_idx = i; end
   endtask

   task automatic test_reset();
      reset = 1'b1; sreset = 1'b1;
      bus.in_valid = 1'b0; bus.data = '0; bus.round_mode = RND_TRUNC;
      sbus.in_valid = 1'b0; sbus.data = '0; sbus.round_mode = RND_TRUNC;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.valid !== 1'b0 || bus.out !== '0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: valid=%0b out=%0d done=%0b, expected 0/0/0", bus.valid, bus.out, bus.done);
      end
      checks++;
      if (sbus.valid !== 1'b0 || sbus.out !== '0 || sbus.done !== 1'b0) begin
         errors++;
         $display("FAIL reset_state_small: valid=%0b out=%0d done=%0b, expected 0/0/0", sbus.valid, sbus.out, sbus.done);
      end
      reset = 1'b0; sreset = 1'b0;
      last_out = 0;
      mon_en = 1'b1;
   endtask

   task automatic test_basic();
      int n, li;
      cap.delete();
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++)
            send(8*r + c, RND_TRUNC);
      drain("basic");
      count_done(n, li);
      checks++;
      if (cap.size() != 120 || cap[0].val != 4 || cap[119].val != 123) begin
         errors++;
         $display("FAIL basic_frame: count=%0d first=%0d last=%0d, expected 120/4/123",
                  cap.size(), cap[0].val, cap[cap.size()-1].val);
      end
      checks++;
      if (n != 1 || li != 119) begin
         errors++;
         $display("FAIL basic_done: pulses=%0d at=%0d, expected 1 at 119", n, li);
      end
      ref_q.delete();
      foreach (cap[i]) ref_q.push_back(cap[i].val);
   endtask

   task automatic test_gaps();
      int bad = 0;
      cap.delete();
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++) begin
            while ($urandom_range(1) == 0) idle();
            send(8*r + c, RND_TRUNC);
         end
      drain("gaps");
      foreach (cap[i]) if (i < ref_q.size() && cap[i].val != ref_q[i]) bad++;
      checks++;
      if (cap.size() != 120 || bad != 0) begin
         errors++;
         $display("FAIL gaps_sequence: count=%0d differing=%0d, expected 120/0", cap.size(), bad);
      end
   endtask

   task automatic test_back_to_back();
      int n, li, first_done;
      cap.delete();
      for (int f = 0; f < 2; f++)
         for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
               send(f == 0 ? 8*r + c : 255 - (8*r + c), RND_TRUNC);
      drain("b2b");
      count_done(n, li);
      first_done = -1;
      foreach (cap[i]) if (cap[i].done && first_done < 0) first_done = i;
      checks++;
      if (cap.size() != 240 || n != 2 || first_done != 119 || li != 239) begin
         errors++;
         $display("FAIL b2b_done: count=%0d pulses=%0d at %0d,%0d, expected 240/2 at 119,239",
                  cap.size(), n, first_done, li);
      end
      checks++;
      if (cap[120].val != 251) begin
         errors++;
         $display("FAIL b2b_second_first: out=%0d, expected 251", cap[120].val);
      end
   endtask

   task automatic test_extremes();
      int row0[NC] = '{255, 255, 255, 3, 3, 0, 0, 0};
      int row1[5]  = '{255, 0, 0, 4, 4};
      bit rm1[5]   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      int exp5[5]  = '{255, 127, 128, 3, 4};
      cap.delete();
      for (int c = 0; c < NC; c++) send(row0[c], RND_TRUNC);
      for (int c = 0; c < NC; c++) send(c < 5 ? row1[c] : 0, c < 5 ? rm1[c] : RND_TRUNC);
      for (int r = 2; r < NR; r++)
         for (int c = 0; c < NC; c++) send(0, RND_HALF_UP);
      drain("extremes");
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (cap.size() <= i || cap[i].val != exp5[i]) begin
            errors++;
            $display("FAIL extreme_%0d: out=%0d, expected %0d", i, cap.size() > i ? cap[i].val : -1, exp5[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      for (int s = 0; s < 43; s++) send(s, RND_TRUNC);
      @(negedge clk);
      reset = 1'b1;
      bus.data = DW'(77);
      bus.in_valid = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      bus.in_valid = 1'b0;
      checks++;
      if (bus.valid !== 1'b0 || bus.out !== '0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_state: valid=%0b out=%0d done=%0b, expected 0/0/0", bus.valid, bus.out, bus.done);
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL reset_mid_pending: %0d outputs missing, expected 0", sb.size());
      end
      m_col = 0; m_row = 0;
      cap.delete();
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++)
            send(8*r + c, RND_TRUNC);
      drain("reset_mid");
      checks++;
      if (cap.size() != 120 || cap[0].val != 4) begin
         errors++;
         $display("FAIL reset_mid_frame: count=%0d first=%0d, expected 120/4", cap.size(), cap[0].val);
      end
   endtask

   task automatic small_send(input int d, input bit rm, input bit ev, input int eo, input bit ed);
      @(negedge clk);
      sbus.data = 4'(d);
      sbus.in_valid = 1'b1;
      sbus.round_mode = rm;
      @(posedge clk);
      #1;
      checks++;
      if (sbus.valid !== ev || sbus.done !== ed || (ev && sbus.out !== 4'(eo))) begin
         errors++;
         $display("FAIL small_sample: valid=%0b out=%0d done=%0b, expected valid=%0b out=%0d done=%0b",
                  sbus.valid, sbus.out, sbus.done, ev, eo, ed);
      end
   endtask

   task automatic test_small();
      small_send(1, 0, 0, 0, 0);
      small_send(2, 0, 0, 0, 0);
      small_send(3, 0, 0, 0, 0);
      small_send(5, 0, 1, 3, 0);
      small_send(7, 0, 1, 4, 0);
      small_send(9, 0, 1, 6, 1);
      small_send(15, 1, 0, 0, 0);
      small_send(15, 1, 0, 0, 0);
      small_send(0, 1, 0, 0, 0);
      small_send(15, 1, 1, 15, 0);
      small_send(0, 1, 1, 8, 0);
      small_send(1, 1, 1, 1, 1);
      @(negedge clk);
      sbus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (sbus.valid !== 1'b0 || sbus.done !== 1'b0 || sbus.out !== 4'd1) begin
         errors++;
         $display("FAIL small_idle: valid=%0b out=%0d done=%0b, expected 0/1/0", sbus.valid, sbus.out, sbus.done);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_basic();
      test_gaps();
      test_back_to_back();
      test_extremes();
      test_reset_mid();
      test_small();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
